// File: rtl/am2901_slice_n.sv
// Parametrised Am2901-style bit slice: two-port register file, Q register,
// 8-function ALU with carry-lookahead flags, RAM/Q shifters and a registered status word.
module am2901_slice_n #(
  parameter int WIDTH = 4,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             en,
  input  logic [8:0]       i,
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  input  logic [WIDTH-1:0] d,
  input  logic             cin,
  input  logic             oe_n,
  output logic [WIDTH-1:0] y,
  output logic             y_en,
  input  logic             ram0_in,
  input  logic             ramn_in,
  output logic             ram0_out,
  output logic             ram0_oe,
  output logic             ramn_out,
  output logic             ramn_oe,
  input  logic             q0_in,
  input  logic             qn_in,
  output logic             q0_out,
  output logic             q0_oe,
  output logic             qn_out,
  output logic             qn_oe,
  output logic             cout,
  output logic             g_n,
  output logic             p_n,
  output logic             ovr,
  output logic             z,
  output logic             f_msb,
  input  logic             stat_we,
  output logic [3:0]       stat_q
);

  logic [WIDTH-1:0] ram [NREGS];
  logic [WIDTH-1:0] q_reg;
  logic [3:0]       stat_r;

  logic [2:0]       src, fn, dst;
  logic [WIDTH-1:0] a_rd, b_rd;
  logic [WIDTH-1:0] r_op, s_op, x_op, y_op, f;
  logic [WIDTH:0]   sum;
  logic             arith, carry_msb, grp_gen;
  logic             ram_we, q_we;
  logic [WIDTH-1:0] ram_d, q_d;

  assign src  = i[2:0];
  assign fn   = i[5:3];
  assign dst  = i[8:6];
  assign a_rd = ram[a];
  assign b_rd = ram[b];

  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src)
      3'd0: begin r_op = a_rd; s_op = q_reg; end
      3'd1: begin r_op = a_rd; s_op = b_rd;  end
      3'd2: begin r_op = '0;   s_op = q_reg; end
      3'd3: begin r_op = '0;   s_op = b_rd;  end
      3'd4: begin r_op = '0;   s_op = a_rd;  end
      3'd5: begin r_op = d;    s_op = a_rd;  end
      3'd6: begin r_op = d;    s_op = q_reg; end
      default: begin r_op = d; s_op = '0;    end
    endcase
  end

  // Subtracts are done by inverting one operand ahead of a single adder.
  always_comb begin
    x_op = (fn == 3'd1) ? ~r_op : r_op;
    y_op = (fn == 3'd2) ? ~s_op : s_op;
    sum  = {1'b0, x_op} + {1'b0, y_op} + (WIDTH+1)'(cin);
    f    = '0;
    case (fn)
      3'd0, 3'd1, 3'd2: f = sum[WIDTH-1:0];
      3'd3: f = r_op | s_op;
      3'd4: f = r_op & s_op;
      3'd5: f = ~r_op & s_op;
      3'd6: f = r_op ^ s_op;
      default: f = ~(r_op ^ s_op);
    endcase
  end

  assign arith     = (fn == 3'd0) || (fn == 3'd1) || (fn == 3'd2);
  assign carry_msb = x_op[WIDTH-1] ^ y_op[WIDTH-1] ^ sum[WIDTH-1];
  // Group generate is the carry of X+Y alone: cin only adds a carry when every bit propagates.
  assign grp_gen   = sum[WIDTH] & ~(cin & (&(x_op ^ y_op)));

  assign cout  = arith & sum[WIDTH];
  assign ovr   = arith & (carry_msb ^ sum[WIDTH]);
  assign g_n   = ~(arith & grp_gen);
  assign p_n   = ~(arith & (&(x_op | y_op)));
  assign z     = (f == '0);
  assign f_msb = f[WIDTH-1];

  assign ram_we = dst[2] | dst[1];
  assign q_we   = (dst == 3'd0) || (dst == 3'd4) || (dst == 3'd6);

  always_comb begin
    ram_d = f;
    q_d   = q_reg;
    case (dst)
      3'd0: q_d = f;
      3'd4: begin
        ram_d = {ramn_in, f[WIDTH-1:1]};
        q_d   = {qn_in, q_reg[WIDTH-1:1]};
      end
      3'd5: ram_d = {ramn_in, f[WIDTH-1:1]};
      3'd6: begin
        ram_d = {f[WIDTH-2:0], ram0_in};
        q_d   = {q_reg[WIDTH-2:0], q0_in};
      end
      3'd7: ram_d = {f[WIDTH-2:0], ram0_in};
      default: ;
    endcase
  end

  assign y    = (dst == 3'd2) ? a_rd : f;
  assign y_en = ~oe_n;

  assign ram0_oe  = (dst == 3'd4) || (dst == 3'd5);
  assign ram0_out = ram0_oe & f[0];
  assign ramn_oe  = (dst == 3'd6) || (dst == 3'd7);
  assign ramn_out = ramn_oe & f[WIDTH-1];
  assign q0_oe    = (dst == 3'd4);
  assign q0_out   = q0_oe & q_reg[0];
  assign qn_oe    = (dst == 3'd6);
  assign qn_out   = qn_oe & q_reg[WIDTH-1];

  assign stat_q = stat_r;

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) ram[k] <= '0;
      q_reg  <= '0;
      stat_r <= '0;
    end else if (en) begin
      if (ram_we)  ram[b] <= ram_d;
      if (q_we)    q_reg  <= q_d;
      if (stat_we) stat_r <= {f_msb, z, ovr, cout};
    end
  end

endmodule

// File: tb/tb_am2901_slice_n.sv
// Directed bench for am2901_slice_n: an 8-bit/16-reg slice and a 16-bit/32-reg slice,
// expected values queued by the stimulus and compared by a negedge monitor.
module tb_am2901_slice_n;

  localparam int D_QREG = 0, D_NOP = 1, D_RAMA = 2, D_RAMF = 3,
                 D_RAMQD = 4, D_RAMD = 5, D_RAMQU = 6, D_RAMU = 7;
  localparam int F_ADD = 0, F_SUBR = 1, F_SUBS = 2, F_OR = 3,
                 F_AND = 4, F_NOTRS = 5, F_EXOR = 6, F_EXNOR = 7;
  localparam int SRC_AQ = 0, SRC_AB = 1, SRC_ZQ = 2, SRC_ZB = 3,
                 SRC_ZA = 4, SRC_DA = 5, SRC_DQ = 6, SRC_DZ = 7;
  localparam int O_Y = 0, O_YEN = 1, O_COUT = 2, O_Z = 3, O_OVR = 4, O_FMSB = 5,
                 O_GN = 6, O_PN = 7, O_STAT = 8, O_SH = 9, O_Y16 = 10, O_SH16 = 11;

  logic cp = 1'b0;
  always #5 cp = ~cp;

  // 8-bit, 16-register slice
  logic       rst_n, en, cin, oe_n, stat_we, ram0_in, ramn_in, q0_in, qn_in;
  logic [8:0] i;
  logic [3:0] a, b;
  logic [7:0] d, y;
  logic       y_en, ram0_out, ram0_oe, ramn_out, ramn_oe, q0_out, q0_oe, qn_out, qn_oe;
  logic       cout, g_n, p_n, ovr, z, f_msb;
  logic [3:0] stat_q;

  am2901_slice_n #(.WIDTH(8), .NREGS(16)) dut8 (
    .cp(cp), .rst_n(rst_n), .en(en), .i(i), .a(a), .b(b), .d(d), .cin(cin),
    .oe_n(oe_n), .y(y), .y_en(y_en), .ram0_in(ram0_in), .ramn_in(ramn_in),
    .ram0_out(ram0_out), .ram0_oe(ram0_oe), .ramn_out(ramn_out), .ramn_oe(ramn_oe),
    .q0_in(q0_in), .qn_in(qn_in), .q0_out(q0_out), .q0_oe(q0_oe),
    .qn_out(qn_out), .qn_oe(qn_oe), .cout(cout), .g_n(g_n), .p_n(p_n),
    .ovr(ovr), .z(z), .f_msb(f_msb), .stat_we(stat_we), .stat_q(stat_q)
  );

  // 16-bit, 32-register slice
  logic        w_rst_n, w_en, w_cin, w_oe_n, w_stat_we, w_ram0_in, w_ramn_in, w_q0_in, w_qn_in;
  logic [8:0]  w_i;
  logic [4:0]  w_a, w_b;
  logic [15:0] w_d, w_y;
  logic        w_y_en, w_ram0_out, w_ram0_oe, w_ramn_out, w_ramn_oe;
  logic        w_q0_out, w_q0_oe, w_qn_out, w_qn_oe;
  logic        w_cout, w_g_n, w_p_n, w_ovr, w_z, w_f_msb;
  logic [3:0]  w_stat_q;

  am2901_slice_n #(.WIDTH(16), .NREGS(32)) dut16 (
    .cp(cp), .rst_n(w_rst_n), .en(w_en), .i(w_i), .a(w_a), .b(w_b), .d(w_d), .cin(w_cin),
    .oe_n(w_oe_n), .y(w_y), .y_en(w_y_en), .ram0_in(w_ram0_in), .ramn_in(w_ramn_in),
    .ram0_out(w_ram0_out), .ram0_oe(w_ram0_oe), .ramn_out(w_ramn_out), .ramn_oe(w_ramn_oe),
    .q0_in(w_q0_in), .qn_in(w_qn_in), .q0_out(w_q0_out), .q0_oe(w_q0_oe),
    .qn_out(w_qn_out), .qn_oe(w_qn_oe), .cout(w_cout), .g_n(w_g_n), .p_n(w_p_n),
    .ovr(w_ovr), .z(w_z), .f_msb(w_f_msb), .stat_we(w_stat_we), .stat_q(w_stat_q)
  );

  // shift pins packed {ram0_out, ram0_oe, ramn_out, ramn_oe, q0_out, q0_oe, qn_out, qn_oe}
  logic [7:0] sh8, sh16;
  assign sh8  = {ram0_out, ram0_oe, ramn_out, ramn_oe, q0_out, q0_oe, qn_out, qn_oe};
  assign sh16 = {w_ram0_out, w_ram0_oe, w_ramn_out, w_ramn_oe,
                 w_q0_out, w_q0_oe, w_qn_out, w_qn_oe};

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [15:0] observe(int sig);
    case (sig)
      O_Y:    return {8'h00, y};
      O_YEN:  return {15'h0, y_en};
      O_COUT: return {15'h0, cout};
      O_Z:    return {15'h0, z};
      O_OVR:  return {15'h0, ovr};
      O_FMSB: return {15'h0, f_msb};
      O_GN:   return {15'h0, g_n};
      O_PN:   return {15'h0, p_n};
      O_STAT: return {12'h0, stat_q};
      O_SH:   return {8'h00, sh8};
      O_Y16:  return w_y;
      O_SH16: return {8'h00, sh16};
      default: return 16'hxxxx;
    endcase
  endfunction

  always @(negedge cp) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] got;
      e   = sb.pop_front();
      got = observe(e.sig);
      n_vec++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.exp);
      end
    end
  end

  function automatic logic [8:0] op(int dst, int fnc, int src);
    logic [2:0] dd, ff, ss;
    dd = dst[2:0];
    ff = fnc[2:0];
    ss = src[2:0];
    return {dd, ff, ss};
  endfunction

  task automatic chk(input string n, input int s, input logic [15:0] e);
    sb.push_back('{n, s, e});
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic rd_a(input logic [3:0] addr, input logic [7:0] e, input string n);
    i = op(D_NOP, F_OR, SRC_ZA);
    a = addr;
    chk(n, O_Y, {8'h00, e});
    step();
  endtask

  task automatic rd_q(input logic [7:0] e, input string n);
    i = op(D_NOP, F_OR, SRC_ZQ);
    chk(n, O_Y, {8'h00, e});
    step();
  endtask

  typedef struct { int fnc; logic [7:0] yv; string n; } logic_vec_t;
  logic_vec_t lv[4];

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; en = 0; i = '0; a = '0; b = '0; d = '0; cin = 0; oe_n = 0;
    stat_we = 0; ram0_in = 0; ramn_in = 0; q0_in = 0; qn_in = 0;
    w_rst_n = 0; w_en = 0; w_i = '0; w_a = '0; w_b = '0; w_d = '0; w_cin = 0; w_oe_n = 0;
    w_stat_we = 0; w_ram0_in = 0; w_ramn_in = 0; w_q0_in = 0; w_qn_in = 0;
    step();

    chk("rst_y", O_Y, 0);      chk("rst_z", O_Z, 1);     chk("rst_cout", O_COUT, 0);
    chk("rst_ovr", O_OVR, 0);  chk("rst_sh", O_SH, 0);   chk("rst_stat", O_STAT, 0);
    chk("rst_yen", O_YEN, 1);  chk("rst_gn", O_GN, 1);   chk("rst_pn", O_PN, 1);
    step();

    rst_n = 1; en = 1;
    i = op(D_RAMF, F_OR, SRC_DZ); b = 3; d = 8'h5A;
    chk("wr3_y", O_Y, 16'h5A); chk("wr3_z", O_Z, 0);
    step();
    chk("stat_after_wr", O_STAT, 0);
    rd_a(3, 8'h5A, "rd_r3_5a");
    rd_q(8'h00, "rd_q_zero");

    i = op(D_RAMF, F_ADD, SRC_AB); a = 3; b = 3; cin = 0; stat_we = 1;
    chk("add_y", O_Y, 16'hB4);   chk("add_cout", O_COUT, 0); chk("add_ovr", O_OVR, 1);
    chk("add_z", O_Z, 0);        chk("add_fmsb", O_FMSB, 1); chk("add_gn", O_GN, 1);
    chk("add_pn", O_PN, 1);
    step();
    stat_we = 0;
    chk("add_stat", O_STAT, 4'b1010);
    rd_a(3, 8'hB4, "rd_r3_b4");

    i = op(D_RAMF, F_OR, SRC_DZ); b = 2; d = 8'h40;
    step();

    i = op(D_NOP, F_SUBR, SRC_DA); a = 2; d = 8'h40; cin = 1;
    chk("subr_y", O_Y, 0);       chk("subr_z", O_Z, 1);      chk("subr_cout", O_COUT, 1);
    chk("subr_ovr", O_OVR, 0);   chk("subr_fmsb", O_FMSB, 0); chk("subr_pn", O_PN, 0);
    chk("subr_gn", O_GN, 1);
    step();

    i = op(D_NOP, F_ADD, SRC_DA); a = 2; d = 8'hC0; cin = 0;
    chk("addc_y", O_Y, 0);       chk("addc_cout", O_COUT, 1); chk("addc_gn", O_GN, 0);
    chk("addc_pn", O_PN, 1);     chk("addc_ovr", O_OVR, 0);
    step();

    i = op(D_NOP, F_SUBS, SRC_DA); a = 2; d = 8'h10; cin = 1;
    chk("subs_y", O_Y, 16'hD0);  chk("subs_cout", O_COUT, 0); chk("subs_fmsb", O_FMSB, 1);
    chk("subs_ovr", O_OVR, 0);
    step();

    lv[0] = '{F_AND,   8'h40, "and"};
    lv[1] = '{F_NOTRS, 8'h00, "notrs"};
    lv[2] = '{F_EXOR,  8'hB0, "exor"};
    lv[3] = '{F_EXNOR, 8'h4F, "exnor"};
    for (int k = 0; k < 4; k++) begin
      i = op(D_NOP, lv[k].fnc, SRC_DA); a = 2; d = 8'hF0; cin = 1;
      chk({lv[k].n, "_y"}, O_Y, {8'h00, lv[k].yv});
      chk({lv[k].n, "_cout"}, O_COUT, 0);
      chk({lv[k].n, "_gn"}, O_GN, 1);
      step();
    end
    cin = 0;
    chk("stat_hold_nop", O_STAT, 4'b1010);
    rd_a(2, 8'h40, "rd_r2_nochange");

    i = op(D_QREG, F_OR, SRC_DZ); d = 8'h81;
    step();
    i = op(D_RAMF, F_OR, SRC_DZ); b = 5; d = 8'h03;
    step();

    i = op(D_RAMQD, F_OR, SRC_ZB); b = 5; ramn_in = 1; qn_in = 0;
    chk("ramqd_y", O_Y, 16'h03); chk("ramqd_sh", O_SH, 16'hCC);
    step();
    ramn_in = 0;
    rd_a(5, 8'h81, "rd_r5_qd");
    rd_q(8'h40, "rd_q_qd");

    i = op(D_RAMQU, F_OR, SRC_ZB); b = 5; ram0_in = 1; q0_in = 1;
    chk("ramqu_y", O_Y, 16'h81); chk("ramqu_sh", O_SH, 16'h31);
    step();
    ram0_in = 0; q0_in = 0;
    rd_a(5, 8'h03, "rd_r5_qu");
    rd_q(8'h81, "rd_q_qu");

    i = op(D_RAMD, F_OR, SRC_ZB); b = 5;
    chk("ramd_sh", O_SH, 16'hC0);
    step();
    rd_a(5, 8'h01, "rd_r5_d");

    en = 0; stat_we = 1;
    for (int k = 0; k < 3; k++) begin
      i = op(D_QREG, F_OR, SRC_DZ); d = 8'hFF;
      chk("en0_y", O_Y, 16'hFF);
      step();
    end
    stat_we = 0;
    chk("en0_stat_hold", O_STAT, 4'b1010);
    rd_q(8'h81, "rd_q_en0_hold");
    en = 1;
    i = op(D_QREG, F_OR, SRC_DZ); d = 8'hFF;
    step();
    rd_q(8'hFF, "rd_q_en1");

    en = 0; rst_n = 0;
    i = op(D_RAMF, F_OR, SRC_DZ); b = 3; d = 8'h99;
    step();
    rst_n = 1; en = 1;
    chk("rst2_stat", O_STAT, 0);
    rd_q(8'h00, "rd_q_rst2");
    rd_a(3, 8'h00, "rd_r3_rst2");
    rd_a(5, 8'h00, "rd_r5_rst2");

    rst_n = 0; en = 1;
    i = op(D_RAMF, F_OR, SRC_DZ); b = 7; d = 8'h66;
    step();
    rst_n = 1;
    rd_a(7, 8'h00, "rd_r7_discard");

    i = op(D_RAMF, F_OR, SRC_DZ); b = 3; d = 8'h11;
    step();
    i = op(D_RAMA, F_OR, SRC_DZ); a = 3; b = 4; d = 8'h22; oe_n = 1;
    chk("rama_y", O_Y, 16'h11); chk("oe_yen", O_YEN, 0);
    step();
    oe_n = 0;
    chk("oe_yen_back", O_YEN, 1);
    rd_a(4, 8'h22, "rd_r4_rama");

    i = op(D_RAMA, F_OR, SRC_DZ); a = 6; b = 6; d = 8'h77;
    chk("nobypass_y", O_Y, 16'h00);
    step();
    rd_a(6, 8'h77, "rd_r6_next");

    w_rst_n = 1; w_en = 1;
    w_i = op(D_RAMF, F_OR, SRC_DZ); w_b = 17; w_d = 16'h8000;
    step();
    w_i = op(D_RAMU, F_OR, SRC_ZB); w_b = 17; w_ram0_in = 1;
    chk("w_ramu_y", O_Y16, 16'h8000); chk("w_ramu_sh", O_SH16, 16'h30);
    step();
    w_ram0_in = 0;
    w_i = op(D_NOP, F_OR, SRC_ZA); w_a = 17;
    chk("w_rd_r17", O_Y16, 16'h0001);
    step();
    w_a = 1;
    chk("w_rd_r1", O_Y16, 16'h0000);
    step();

    @(negedge cp);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
